fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the memory's `pc` input, and captures the returned 32-bit `instruction_code` into an IF/ID pipeline register. That register is offered to decode with a valid/ready handshake. The block supports sequential fetch, backpressure stalls and branch/jump redirects with a flush, wrapping within the 128-byte instruction space.

---
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage in front of the instruction memory. It owns the
//   program counter, drives it to the memory, and registers the returned
//   instruction into an IF/ID register. Decode takes that register through a
//   valid/ready handshake. Supported operations are sequential fetch, stalls
//   under backpressure, and branch/jump redirects with a flush. All addresses
//   wrap inside an IMEM_BYTES-sized space.
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN
//     defined   : a misaligned redirect in RUN traps. It sets the sticky
//                 'fault' flag and freezes the unit until reset.
//     undefined : redirect targets are rounded down to a word boundary, and
//                 'fault' is tied 0.
//
// Parameters
//   RESET_PC        PC loaded on reset (word aligned, < IMEM_BYTES)
//   IMEM_BYTES      instruction memory size in bytes (power of two, >= 8)
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   imem_pc         byte address to instruction memory (copy of pc_q)
//   imem_instr      instruction returned combinationally for imem_pc
//   redirect_valid  taken branch/jump this cycle
//   redirect_pc     redirect target byte address
//   id_valid        IF/ID register holds an instruction
//   id_ready        decode accepts the instruction this cycle
//   id_instr        fetched instruction
//   id_pc           address of id_instr
//   id_pc_plus4     id_pc + 4, wrapped
//   fetch_count     number of completed IF->ID handshakes (wraps)
//   fault           sticky misaligned-redirect trap flag
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] fetch_count,
  output logic        fault
);

  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_seq;        // next sequential PC, wrapped
  logic [31:0] redirect_tgt;  // wrapped and word-aligned redirect target
  logic        trap_req;      // misaligned redirect that must trap
  logic        do_load;
  logic        do_redirect;
  logic        do_trap;

  assign pc_seq       = (pc_q + 32'd4) & ADDR_MASK;
  assign redirect_tgt = redirect_pc & ADDR_MASK & ~32'h3;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap_req = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign trap_req = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (trap_req) state_d = S_FAULT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  // ------------------------------------------------------------- FSM outputs
  // A redirect taken in BOOT only updates the PC. The trap is a RUN-only event.
  always_comb begin
    do_load     = 1'b0;
    do_redirect = 1'b0;
    do_trap     = 1'b0;
    unique case (state_q)
      S_BOOT: do_redirect = redirect_valid;
      S_RUN: begin
        if (trap_req) begin
          do_trap = 1'b1;
        end else if (redirect_valid) begin
          do_redirect = 1'b1;
        end else begin
          do_load = !id_valid_q || id_ready;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    // A transfer that coincides with a redirect or a trap still counts.
    fetch_count_d = fetch_count_q + {31'd0, id_valid_q && id_ready};

    if (do_trap) begin
      id_valid_d = 1'b0;
    end else if (do_redirect) begin
      pc_d       = redirect_tgt;
      id_valid_d = 1'b0;
    end else if (do_load) begin
      id_instr_d    = imem_instr;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_seq;
      id_valid_d    = 1'b1;
      pc_d          = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= 32'd0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      fetch_count_q <= fetch_count_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (do_trap) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign imem_pc     = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Scoreboard bench for fetch_unit. Each scenario pushes the PCs it expects
//   decode to receive, in order. A negedge monitor pops one entry per
//   handshake. It then checks id_pc, id_instr and id_pc_plus4 against a
//   behavioural ROM image. It also checks fetch_count against the number of
//   handshakes seen.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] MASK = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] fetch_count;
  logic        fault;

  int tests_run    = 0;
  int tests_failed = 0;
  int hs_seen      = 0;
  bit mon_en       = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fetch_count    (fetch_count),
    .fault          (fault)
  );

  // Standard image: add/sub-style words; 0x20 holds 0x4020A1B3.
  function automatic logic [31:0] img(input logic [31:0] a);
    if (a == 32'h20) return 32'h4020A1B3;
    return 32'h002081B3 + (32'(a[6:2]) << 12);
  endfunction

  assign imem_instr = img(imem_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step(1);
    redirect_valid = 1'b0;
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("fetch_count", fetch_count, 32'(hs_seen));
      if (id_valid && id_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("id_pc", id_pc, e);
          check("id_instr", id_instr, img(e));
          check("id_pc_plus4", id_pc_plus4, (e + 32'd4) & MASK);
          $display("[TB] xfer pc=0x%02h instr=0x%08h pc4=0x%02h cnt=%0d",
                   id_pc, id_instr, id_pc_plus4, fetch_count);
        end
        hs_seen++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_instr"}, id_instr, 32'd0);
    check({tag, "_pc"}, id_pc, 32'd0);
    check({tag, "_pc4"}, id_pc_plus4, 32'd0);
    check({tag, "_cnt"}, fetch_count, 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_imem_pc"}, imem_pc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset values; the last reset edge is E0.
    step(3);
    check_reset_vals("rst");

    exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h20, 32'h24, 32'h7C, 32'h00, 32'h04};
    hs_seen = 0;
    mon_en  = 1'b1;
    reset   = 1'b1;
    step(1);                                   // E1: BOOT -> RUN, no load
    check("boot_valid", 32'(id_valid), 32'd0);
    check("boot_imem_pc", imem_pc, 32'h00);
    step(1);                                   // E2: first load
    check("first_valid", 32'(id_valid), 32'd1);
    check("first_pc", id_pc, 32'h00);
    step(2);                                   // id_pc = 0x08 now

    // Stall for three cycles.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_pc", id_pc, 32'h08);
      check("stall_instr", id_instr, 32'h0020A1B3);
      check("stall_imem_pc", imem_pc, 32'h0C);
      check("stall_valid", 32'(id_valid), 32'd1);
      $display("[TB] stall cycle %0d pc=0x%02h imem_pc=0x%02h", i, id_pc, imem_pc);
    end
    id_ready = 1'b1;
    step(1);                                   // 0x08 leaves, 0x0C shown

    // Redirect with a coincident transfer of 0x0C.
    redirect(32'h20);
    check("bubble_valid", 32'(id_valid), 32'd0);
    check("bubble_imem_pc", imem_pc, 32'h20);
    step(1);
    check("tgt_valid", 32'(id_valid), 32'd1);
    check("tgt_pc4", id_pc_plus4, 32'h24);
    step(1);                                   // 0x20 leaves, 0x24 shown

    // Wrap: 0x7C followed by 0x00, then 0x84 aliases to 0x04.
    redirect(32'h7C);
    step(1);                                   // 0x7C shown
    check("wrap_pc4", id_pc_plus4, 32'h00);
    step(1);                                   // 0x00 shown
    redirect(32'h84);
    step(1);                                   // 0x04 shown

    // Misaligned redirect to 0x22 while 0x04 leaves.
    redirect(32'h22);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_fault", 32'(fault), 32'd1);
    check("trap_valid", 32'(id_valid), 32'd0);
    redirect(32'h40);
    step(2);
    check("frozen_fault", 32'(fault), 32'd1);
    check("frozen_valid", 32'(id_valid), 32'd0);
    check("frozen_imem_pc", imem_pc, 32'h08);
`else
    exp_q.push_back(32'h20);
    check("mis_fault", 32'(fault), 32'd0);
    check("mis_imem_pc", imem_pc, 32'h20);
    step(1);                                   // 0x20 shown
    check("mis_pc", id_pc, 32'h20);
    step(1);                                   // 0x20 leaves
`endif

    // Reset while stalled (or trapped).
    id_ready = 1'b0;
    step(1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    mon_en = 1'b0;
    #1;
    reset = 1'b0;
    step(1);
    check_reset_vals("midrst");

    hs_seen  = 0;
    exp_q    = '{32'h00, 32'h04};
    reset    = 1'b1;
    id_ready = 1'b1;
    mon_en   = 1'b1;
    step(2);
    check("rel_pc", id_pc, 32'h00);
    step(2);
    id_ready = 1'b0;
    step(1);
    check("sb_final", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
